// File: rtl/dprs_arb_pkg.sv
// Shared parameters for the dual-port read-sharing arbiter and its memory.
// Keeps the address-width derivation in one place so arbiter and memory agree.
package dprs_arb_pkg;

   localparam int unsigned KB_DEF     = 0;
   localparam int unsigned STARVE_DEF = 3;

   // KB == 0 selects the full 64 KiB address space.
   function automatic int unsigned addr_width(input int unsigned kb);
      return (kb == 0) ? 16 : $clog2(kb * 1024);
   endfunction

   function automatic int unsigned cnt_width(input int unsigned starve);
      return ($clog2(starve + 1) < 2) ? 2 : $clog2(starve + 1);
   endfunction

endpackage

// File: rtl/dprs_arb.sv
// Video/CPU arbiter for a shared 1R1W byte memory: combinational read grant with
// starvation override, registered write port and write-to-read forwarding.
module dprs_arb
   import dprs_arb_pkg::*;
#(
   parameter int unsigned KB     = KB_DEF,
   parameter int unsigned STARVE = STARVE_DEF,
   localparam int unsigned AW    = addr_width(KB),
   localparam int unsigned CW    = cnt_width(STARVE)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [AW-1:0] va,
   input  logic          vreq,
   output logic          vack,
   output logic          vvalid,
   output logic [7:0]    vq,
   input  logic [AW-1:0] ca,
   input  logic          creq,
   output logic          cack,
   output logic          cvalid,
   output logic [7:0]    cq,
   input  logic [AW-1:0] cwa,
   input  logic [7:0]    cd,
   input  logic          cw,
   output logic [AW-1:0] ma1,
   input  logic [7:0]    mq1,
   output logic [AW-1:0] ma2,
   output logic [7:0]    md2,
   output logic          mw2
);

   localparam logic [CW-1:0] StarveCnt = CW'(STARVE);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] ma1_q;
   logic          vvalid_q, cvalid_q;
   logic          mw2_q;
   logic [AW-1:0] ma2_q;
   logic [7:0]    md2_q;
   logic          fwd_q;
   logic [7:0]    fwd_data_q;
   logic          both, cpu_force, hazard;
   logic [7:0]    rdata;

   assign both      = vreq & creq;
   assign cpu_force = both & (cnt_q == StarveCnt);

   // Grants are gated by the reset level so they stay low throughout reset.
   assign vack = reset & vreq & ~cpu_force;
   assign cack = reset & creq & (~vreq | cpu_force);
   assign ma1  = !reset ? '0 : vack ? va : cack ? ca : ma1_q;

   always_comb begin
      cnt_d = cnt_q;
      if (cack) begin
         cnt_d = '0;
      end else if (both && vack) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // A read hitting the write in flight would see stale mq1; latch md2 instead.
   assign hazard = (vack | cack) & mw2_q & (ma1 == ma2_q);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q      <= '0;
         ma1_q      <= '0;
         vvalid_q   <= 1'b0;
         cvalid_q   <= 1'b0;
         mw2_q      <= 1'b0;
         ma2_q      <= '0;
         md2_q      <= '0;
         fwd_q      <= 1'b0;
         fwd_data_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         ma1_q    <= ma1;
         vvalid_q <= vack;
         cvalid_q <= cack;
         mw2_q    <= cw;
         ma2_q    <= cwa;
         md2_q    <= cd;
         fwd_q    <= hazard;
         if (hazard) begin
            fwd_data_q <= md2_q;
         end
      end
   end

   assign rdata  = fwd_q ? fwd_data_q : mq1;
   assign vq     = rdata;
   assign cq     = rdata;
   assign vvalid = vvalid_q;
   assign cvalid = cvalid_q;
   assign mw2    = mw2_q;
   assign ma2    = ma2_q;
   assign md2    = md2_q;

endmodule
